// File: rtl/rv32i_types.sv
// Shared types for the rv32i memory hierarchy.
// Holds the cacheline geometry defaults and the arbiter's FSM state and
// client encodings. The arbiter uses the grant helper below to pick a client.
package rv32i_types;

  // Cacheline geometry defaults: 256-bit lines, 32-byte aligned addresses.
  localparam int LINE_W_DEF   = 256;
  localparam int OFFSET_W_DEF = 5;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_SERVE_I = 3'd1,
    ARB_SERVE_D = 3'd2,
    ARB_DONE_I  = 3'd3,
    ARB_DONE_D  = 3'd4
  } arb_state_t;

  // Which client received the most recent grant.
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_client_t;

  // Returns 1 when the data client should win this grant. A lone requester
  // always wins. On a tie, the client that was not granted last wins, which
  // makes continuous contention alternate strictly.
  function automatic logic pick_data(input logic        i_req,
                                     input logic        d_req,
                                     input arb_client_t last);
    return d_req && (!i_req || (last == GRANT_I));
  endfunction

endpackage

// File: rtl/cache_line_arbiter.sv
// cache_line_arbiter
// Serializes cacheline transactions from the instruction L1 (i_*) and the
// data L1 (d_*) onto one physical-memory port (pmem_*).
//
// Handshake: a client raises its request level (i_read, d_read or d_write)
// and holds it until the matching one-cycle x_resp pulse. Memory commands
// (pmem_read/pmem_write) are likewise held until the one-cycle pmem_resp.
// Address and write data are captured at grant, so later client changes
// are ignored until the next grant.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_read, i_addr        instruction line-fill request
//   i_rdata, i_resp       instruction line and completion pulse
//   d_read, d_write       data line-fill / writeback request
//   d_addr, d_wdata       data address and writeback line
//   d_rdata, d_resp       data line and completion pulse
//   pmem_read/pmem_write  registered memory command
//   pmem_addr/pmem_wdata  registered, line-aligned address and write line
//   pmem_rdata/pmem_resp  memory return data and completion
//   dbg_state             current FSM state, for observation only
module cache_line_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W   = LINE_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [31:0]       i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output arb_state_t        dbg_state
);

  // Clears the byte-offset bits of a forwarded address.
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

  arb_state_t  state;
  arb_client_t last_grant;

  logic i_req;
  logic d_req;
  logic grant_d;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign grant_d = pick_data(i_req, d_req, last_grant);

  // Completion pulses are a pure function of the DONE states, so they last
  // exactly one cycle and vanish the moment reset asserts.
  assign i_resp    = (state == ARB_DONE_I);
  assign d_resp    = (state == ARB_DONE_D);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      last_grant <= GRANT_I;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      pmem_addr  <= '0;
      pmem_wdata <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (i_req || d_req) begin
            // Write data is captured on every grant; it only reaches memory
            // when the command is a write.
            pmem_wdata <= d_wdata;
            if (grant_d) begin
              state      <= ARB_SERVE_D;
              last_grant <= GRANT_D;
              pmem_addr  <= d_addr & ADDR_MASK;
              // d_read with d_write is illegal; the write takes priority.
              pmem_write <= d_write;
              pmem_read  <= ~d_write;
            end else begin
              state      <= ARB_SERVE_I;
              last_grant <= GRANT_I;
              pmem_addr  <= i_addr & ADDR_MASK;
              pmem_write <= 1'b0;
              pmem_read  <= 1'b1;
            end
          end
        end

        ARB_SERVE_I: begin
          if (pmem_resp) begin
            i_rdata   <= pmem_rdata;
            pmem_read <= 1'b0;
            state     <= ARB_DONE_I;
          end
        end

        ARB_SERVE_D: begin
          if (pmem_resp) begin
            // A writeback completion leaves d_rdata untouched.
            if (pmem_read) begin
              d_rdata <= pmem_rdata;
            end
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            state      <= ARB_DONE_D;
          end
        end

        // No grant from DONE: the finishing client's request is still high
        // this cycle and must not be served twice.
        ARB_DONE_I, ARB_DONE_D: begin
          state <= ARB_IDLE;
        end

        default: begin
          state      <= ARB_IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_arbiter.sv
// Self-checking bench for cache_line_arbiter: directed cases for reset,
// latency, tie-breaking, writeback, address capture, mid-transaction reset
// and spurious memory responses, then a randomized run. A transaction-level
// timing model predicts bus commands and completions from grant/response
// timestamps.
module tb_cache_line_arbiter;
  import rv32i_types::*;

  localparam int W = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          i_read = 1'b0;
  logic [31:0]   i_addr = '0;
  logic [W-1:0]  i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [31:0]   d_addr = '0;
  logic [W-1:0]  d_wdata = '0;
  logic [W-1:0]  d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_addr;
  logic [W-1:0]  pmem_wdata;
  logic [W-1:0]  pmem_rdata = '0;
  logic          pmem_resp = 1'b0;
  arb_state_t    dbg_state;

  cache_line_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_read     (i_read),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_addr  (pmem_addr),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp),
    .dbg_state  (dbg_state)
  );

  // Illegal client input: read and write together.
  assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write))
    else $error("illegal d_read and d_write together");

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];   // lines memory returned for reads, in order
  int resp_order[$];        // observed completions: 0 = I, 1 = D

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  int cyc;                 // current cycle number
  int free_at;             // first cycle at whose end a grant may happen
  int owner;               // -1 none, 0 I, 1 D: command on the bus
  int grant_cyc;
  int last;                // client granted last
  logic [31:0] m_addr;
  bit m_wr;
  logic [W-1:0] m_wdata;
  int resp_at;             // cycle in which a resp pulse is due
  int resp_who;
  bit resp_wr;
  logic [W-1:0] exp_i_rdata, exp_d_rdata;

  // ---------------- stimulus knobs ----------------
  int lat_cfg = -1;        // >=0 fixed memory latency, <0 random
  int raise_pct = 0;
  bit mutate_en = 1'b0;
  bit spur_en = 1'b0;
  bit spur_once = 1'b0;
  bit drop_i = 1'b0, drop_d = 1'b0;
  bit go_i = 1'b0, go_d = 1'b0, go_d_wr = 1'b0;
  logic [31:0] go_i_addr, go_d_addr;
  logic [W-1:0] go_d_wdata;
  bit force_d_addr = 1'b0;
  logic [31:0] force_d_addr_v;
  int i_resp_cnt, d_resp_cnt, i_resp_cyc;

  function automatic logic [W-1:0] rand_line();
    logic [W-1:0] l;
    for (int i = 0; i < W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic model_reset();
    cyc = 0; free_at = 0; owner = -1; grant_cyc = 0; last = 0;
    resp_at = -1; resp_who = 0; resp_wr = 1'b0;
    m_addr = '0; m_wr = 1'b0; m_wdata = '0;
    exp_i_rdata = '0; exp_d_rdata = '0;
    exp_q.delete(); resp_order.delete();
    drop_i = 1'b0; drop_d = 1'b0; go_i = 1'b0; go_d = 1'b0;
    force_d_addr = 1'b0; spur_once = 1'b0;
    i_resp_cnt = 0; d_resp_cnt = 0; i_resp_cyc = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- driver + checker: one clock cycle ----------------
  task automatic step();
    int age;
    int who;
    logic [W-1:0] line;
    @(posedge clk);
    #1;
    cyc++;
    if (drop_i) begin i_read = 1'b0; drop_i = 1'b0; end
    if (drop_d) begin d_read = 1'b0; d_write = 1'b0; drop_d = 1'b0; end
    if (go_i) begin i_read = 1'b1; i_addr = go_i_addr; go_i = 1'b0; end
    if (go_d) begin
      d_write = go_d_wr; d_read = !go_d_wr; d_addr = go_d_addr;
      d_wdata = go_d_wdata; go_d = 1'b0;
    end
    if (raise_pct > 0) begin
      if (!i_read && $urandom_range(0, 99) < raise_pct) begin
        i_read = 1'b1; i_addr = $urandom;
      end
      if (!d_read && !d_write && $urandom_range(0, 99) < raise_pct) begin
        if ($urandom_range(0, 1) == 1) d_write = 1'b1; else d_read = 1'b1;
        d_addr = $urandom; d_wdata = rand_line();
      end
    end
    if (mutate_en) begin
      if (owner == 0 && $urandom_range(0, 1) == 1) i_addr = $urandom;
      if (owner == 1 && $urandom_range(0, 1) == 1) begin
        d_addr = $urandom; d_wdata = rand_line();
      end
    end
    if (force_d_addr) begin d_addr = force_d_addr_v; force_d_addr = 1'b0; end
    // memory model
    pmem_resp = 1'b0;
    if (owner >= 0) begin
      age = cyc - (grant_cyc + 1);
      if ((lat_cfg >= 0) ? (age == lat_cfg)
                         : (age >= 6 || $urandom_range(0, 2) == 0)) begin
        pmem_resp = 1'b1; pmem_rdata = rand_line();
      end
    end else if (spur_once || (spur_en && $urandom_range(0, 7) == 0)) begin
      pmem_resp = 1'b1; pmem_rdata = rand_line(); spur_once = 1'b0;
    end

    @(negedge clk);
    check("pmem_read", pmem_read, owner >= 0 && !m_wr);
    check("pmem_write", pmem_write, owner >= 0 && m_wr);
    if (owner >= 0) begin
      check("pmem_addr", pmem_addr, m_addr);
      if (m_wr) check("pmem_wdata", pmem_wdata, m_wdata);
    end
    check("i_resp", i_resp, resp_at == cyc && resp_who == 0);
    check("d_resp", d_resp, resp_at == cyc && resp_who == 1);
    if (resp_at == cyc && !resp_wr) begin
      check("rd_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        line = exp_q.pop_front();
        if (resp_who == 0) exp_i_rdata = line; else exp_d_rdata = line;
      end
    end
    check("i_rdata", i_rdata, exp_i_rdata);
    check("d_rdata", d_rdata, exp_d_rdata);
    if (i_resp) begin resp_order.push_back(0); i_resp_cnt++; i_resp_cyc = cyc; end
    if (d_resp) begin resp_order.push_back(1); d_resp_cnt++; end

    // model update for the edge that ends this cycle
    if (resp_at == cyc) begin
      if (resp_who == 0) drop_i = 1'b1; else drop_d = 1'b1;
    end
    if (owner >= 0 && pmem_resp) begin
      resp_at = cyc + 1; resp_who = owner; resp_wr = m_wr;
      free_at = cyc + 2;
      if (!m_wr) exp_q.push_back(pmem_rdata);
      owner = -1;
    end else if (owner < 0 && cyc >= free_at && (i_read || d_read || d_write)) begin
      if (i_read && (d_read || d_write)) who = (last == 0) ? 1 : 0;
      else who = i_read ? 0 : 1;
      owner = who; last = who; grant_cyc = cyc;
      m_addr = ((who == 1) ? d_addr : i_addr) & 32'hFFFF_FFE0;
      m_wr = (who == 1) && d_write;
      m_wdata = d_wdata;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- test sequence ----------------
  int s;
  logic [W-1:0] saved_line;

  initial begin
    model_reset();
    // reset values while reset is held
    #1;
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_addr", pmem_addr, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    check("rst_i_resp", i_resp, 0);
    check("rst_d_resp", d_resp, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_state", dbg_state, ARB_IDLE);
    do_reset();

    // lone instruction fill, memory latency 4
    lat_cfg = 4;
    go_i = 1'b1; go_i_addr = 32'h0000_0064;
    s = cyc + 1;
    step();
    step();
    check("i_cmd_read", pmem_read, 1);
    check("i_cmd_addr", pmem_addr, 32'h0000_0060);
    run(10);
    check("i_resp_cycle", i_resp_cyc - s, 6);
    check("i_resp_count", i_resp_cnt, 1);

    // simultaneous requests, then continuous contention
    do_reset();
    lat_cfg = 1;
    raise_pct = 100;
    run(40);
    raise_pct = 0;
    run(15);
    for (int i = 0; i < 6; i++)
      check("tie_order", (i < resp_order.size()) ? resp_order[i] : 9,
            (i % 2 == 0) ? 1 : 0);

    // writeback with address change mid-service; d_rdata must survive
    do_reset();
    lat_cfg = 1;
    go_d = 1'b1; go_d_wr = 1'b0; go_d_addr = 32'h0000_0040; go_d_wdata = '0;
    run(8);
    saved_line = exp_d_rdata;
    check("pre_wr_rdata", d_rdata, saved_line);
    lat_cfg = 3;
    d_resp_cnt = 0;
    go_d = 1'b1; go_d_wr = 1'b1; go_d_addr = 32'h0000_1234;
    go_d_wdata = {32{8'hA5}};
    step();
    step();
    check("wr_cmd", pmem_write, 1);
    check("wr_addr", pmem_addr, 32'h0000_1220);
    check("wr_wdata", pmem_wdata, {32{8'hA5}});
    force_d_addr = 1'b1; force_d_addr_v = 32'h0000_2000;
    step();
    check("wr_addr_held", pmem_addr, 32'h0000_1220);
    run(8);
    check("wr_resp_count", d_resp_cnt, 1);
    check("wr_rdata_kept", d_rdata, saved_line);

    // reset while serving an instruction fill
    do_reset();
    lat_cfg = 100;
    go_i = 1'b1; go_i_addr = 32'h0000_0480;
    run(3);
    check("pre_rst_read", pmem_read, 1);
    #2 rst_n = 1'b0;
    i_read = 1'b0;
    #1;
    check("async_rst_read", pmem_read, 0);
    check("async_rst_addr", pmem_addr, 0);
    check("async_rst_state", dbg_state, ARB_IDLE);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    run(10);
    check("no_stale_resp", i_resp_cnt, 0);
    lat_cfg = 2;
    go_i = 1'b1; go_i_addr = 32'h0000_0500;
    run(8);
    check("fresh_resp", i_resp_cnt, 1);

    // spurious memory response in IDLE
    spur_once = 1'b1;
    step();
    step();
    check("spur_state", dbg_state, ARB_IDLE);
    check("spur_no_resp", i_resp_cnt + d_resp_cnt, 1);

    // randomized traffic
    do_reset();
    lat_cfg = -1;
    raise_pct = 30;
    mutate_en = 1'b1;
    spur_en = 1'b1;
    run(2000);
    raise_pct = 0;
    spur_en = 1'b0;
    mutate_en = 1'b0;
    run(30);
    check("rand_drained", exp_q.size(), 0);
    check("rand_progress", resp_order.size() > 50, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
